// File: rtl/mano_pkg.sv
// Shared constants for the Mano basic computer: opcodes, register-reference
// codes, T-states, ALU operations and the per-opcode instruction length.
package mano_pkg;

  typedef enum logic [2:0] {
    OP_AND = 3'd0,
    OP_ADD = 3'd1,
    OP_LDA = 3'd2,
    OP_STA = 3'd3,
    OP_BUN = 3'd4,
    OP_BSA = 3'd5,
    OP_ISZ = 3'd6,
    OP_REG = 3'd7
  } opcode_e;

  localparam logic [11:0] RR_CLA = 12'h800;
  localparam logic [11:0] RR_CLE = 12'h400;
  localparam logic [11:0] RR_CMA = 12'h200;
  localparam logic [11:0] RR_CME = 12'h100;
  localparam logic [11:0] RR_CIR = 12'h080;
  localparam logic [11:0] RR_CIL = 12'h040;
  localparam logic [11:0] RR_INC = 12'h020;
  localparam logic [11:0] RR_SPA = 12'h010;
  localparam logic [11:0] RR_SNA = 12'h008;
  localparam logic [11:0] RR_SZA = 12'h004;
  localparam logic [11:0] RR_SZE = 12'h002;
  localparam logic [11:0] RR_HLT = 12'h001;

  localparam logic [2:0] T0 = 3'd0;
  localparam logic [2:0] T1 = 3'd1;
  localparam logic [2:0] T2 = 3'd2;
  localparam logic [2:0] T3 = 3'd3;
  localparam logic [2:0] T4 = 3'd4;
  localparam logic [2:0] T5 = 3'd5;
  localparam logic [2:0] T6 = 3'd6;

  typedef enum logic [2:0] {
    ALU_AND,
    ALU_ADD,
    ALU_CMA,
    ALU_CIR,
    ALU_CIL,
    ALU_INC
  } alu_op_e;

  // Final T-state of an instruction, known once IR has been loaded at T1.
  function automatic logic [2:0] last_t(input opcode_e op);
    case (op)
      OP_REG:         return T3;
      OP_STA, OP_BUN: return T4;
      OP_ISZ:         return T6;
      default:        return T5;
    endcase
  endfunction

endpackage

// File: rtl/mano_alu.sv
// Combinational accumulator/extend datapath: AND, ADD, complement,
// rotates through E, and increment.
module mano_alu
  import mano_pkg::*;
#(
  parameter int DW = 16
) (
  input  alu_op_e       op,
  input  logic [DW-1:0] ac,
  input  logic [DW-1:0] dr,
  input  logic          e,
  output logic [DW-1:0] ac_out,
  output logic          e_out
);

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    ac_out = ac;
    e_out  = e;
    case (op)
      ALU_AND: ac_out = ac & dr;
      ALU_ADD: {e_out, ac_out} = {1'b0, ac} + {1'b0, dr};
      ALU_CMA: ac_out = ~ac;
      ALU_CIR: begin
        ac_out = {e, ac[DW-1:1]};
        e_out  = ac[0];
      end
      ALU_CIL: begin
        ac_out = {ac[DW-2:0], e};
        e_out  = ac[DW-1];
      end
      ALU_INC: ac_out = ac + {{(DW-1){1'b0}}, 1'b1};
      default: ;
    endcase
  end

endmodule

// File: rtl/mano_cpu.sv
// Mano basic computer core: T-state sequenced fetch/indirect/execute with an
// on-chip program memory that is loadable only while the core is halted.
module mano_cpu
  import mano_pkg::*;
#(
  parameter int DW     = 16,
  parameter int MEM_AW = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              prog_we,
  input  logic [MEM_AW-1:0] prog_addr,
  input  logic [DW-1:0]     prog_data,
  output logic              halted,
  output logic              instr_done,
  output logic [11:0]       pc_o,
  output logic [DW-1:0]     ac_o,
  output logic              e_o,
  output logic [2:0]        sc_o
);

  logic [DW-1:0] mem [2**MEM_AW];
  logic [11:0]   pc, ar;
  logic [DW-1:0] ir, dr, ac;
  logic          e, i_bit;
  logic [2:0]    sc;

  opcode_e       op;
  logic [11:0]   rr_code;
  logic [DW-1:0] mem_rd;
  alu_op_e       alu_op;
  logic [DW-1:0] alu_ac;
  logic          alu_e;

  assign op      = opcode_e'(ir[14:12]);
  assign rr_code = ir[11:0];
  assign mem_rd  = mem[ar[MEM_AW-1:0]];

  always_comb begin
    alu_op = ALU_ADD;
    if (op == OP_AND) begin
      alu_op = ALU_AND;
    end else if (op == OP_REG) begin
      case (rr_code)
        RR_CMA:  alu_op = ALU_CMA;
        RR_CIR:  alu_op = ALU_CIR;
        RR_CIL:  alu_op = ALU_CIL;
        RR_INC:  alu_op = ALU_INC;
        default: alu_op = ALU_ADD;
      endcase
    end
  end

  mano_alu #(.DW(DW)) u_alu (
    .op     (alu_op),
    .ac     (ac),
    .dr     (dr),
    .e      (e),
    .ac_out (alu_ac),
    .e_out  (alu_e)
  );

  assign instr_done = !halted && (sc == last_t(op));

  // Single write port: program loading while halted, otherwise STA/BSA/ISZ.
  logic              mem_we;
  logic [MEM_AW-1:0] mem_wa;
  logic [DW-1:0]     mem_wd;

  always_comb begin
    mem_we = 1'b0;
    mem_wa = ar[MEM_AW-1:0];
    mem_wd = ac;
    if (halted) begin
      mem_we = prog_we;
      mem_wa = prog_addr;
      mem_wd = prog_data;
    end else if (sc == T4 && op == OP_STA) begin
      mem_we = 1'b1;
    end else if (sc == T4 && op == OP_BSA) begin
      mem_we = 1'b1;
      mem_wd = {{(DW-12){1'b0}}, pc};
    end else if (sc == T6 && op == OP_ISZ) begin
      mem_we = 1'b1;
      mem_wd = dr;
    end
    if (rst) mem_we = 1'b0;
  end

  // NOTE: the memory array has no reset; its contents must survive rst.
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_wa] <= mem_wd;
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc     <= '0;
      ar     <= '0;
      ir     <= '0;
      dr     <= '0;
      ac     <= '0;
      e      <= 1'b0;
      i_bit  <= 1'b0;
      sc     <= T0;
      halted <= 1'b1;
    end else if (halted) begin
      if (start) begin
        halted <= 1'b0;
        sc     <= T0;
      end
    end else begin
      sc <= instr_done ? T0 : sc + 3'd1;
      case (sc)
        T0: ar <= pc;
        T1: begin
          ir <= mem_rd;
          pc <= pc + 12'd1;
        end
        T2: begin
          ar    <= ir[11:0];
          i_bit <= ir[15];
        end
        T3: begin
          if (op != OP_REG) begin
            if (i_bit) ar <= mem_rd[11:0];
          end else if (!i_bit && $onehot(rr_code)) begin
            case (rr_code)
              RR_CLA: ac <= '0;
              RR_CLE: e  <= 1'b0;
              RR_CME: e  <= ~e;
              RR_CMA, RR_CIR, RR_CIL, RR_INC: begin
                ac <= alu_ac;
                e  <= alu_e;
              end
              RR_SPA: if (!ac[DW-1]) pc <= pc + 12'd1;
              RR_SNA: if (ac[DW-1])  pc <= pc + 12'd1;
              RR_SZA: if (ac == '0)  pc <= pc + 12'd1;
              RR_SZE: if (!e)        pc <= pc + 12'd1;
              RR_HLT: halted <= 1'b1;
              default: ;
            endcase
          end
        end
        T4: begin
          case (op)
            OP_AND, OP_ADD, OP_LDA, OP_ISZ: dr <= mem_rd;
            OP_BUN: pc <= ar;
            OP_BSA: ar <= ar + 12'd1;
            default: ;
          endcase
        end
        T5: begin
          case (op)
            OP_AND: ac <= alu_ac;
            OP_ADD: begin
              ac <= alu_ac;
              e  <= alu_e;
            end
            OP_LDA: ac <= dr;
            OP_BSA: pc <= ar;
            OP_ISZ: dr <= dr + {{(DW-1){1'b0}}, 1'b1};
            default: ;
          endcase
        end
        T6: if (dr == '0) pc <= pc + 12'd1;
        default: ;
      endcase
    end
  end

  assign pc_o = pc;
  assign ac_o = ac;
  assign e_o  = e;
  assign sc_o = sc;

endmodule

// File: tb/tb_mano_cpu.sv
// Bench for mano_cpu: an instruction-level reference model is stepped once per
// instruction and compared against the core every running cycle.
module tb_mano_cpu;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        prog_we = 1'b0;
  logic [5:0]  prog_addr = '0;
  logic [15:0] prog_data = '0;
  logic        halted, instr_done, e_o;
  logic [11:0] pc_o;
  logic [15:0] ac_o;
  logic [2:0]  sc_o;

  mano_cpu #(.DW(16), .MEM_AW(6)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .prog_we    (prog_we),
    .prog_addr  (prog_addr),
    .prog_data  (prog_data),
    .halted     (halted),
    .instr_done (instr_done),
    .pc_o       (pc_o),
    .ac_o       (ac_o),
    .e_o        (e_o),
    .sc_o       (sc_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: architectural state plus a mirror of the program memory.
  logic [15:0] mm [64];
  logic [11:0] mpc;
  logic [15:0] mac;
  logic        me, mhalted;
  bit          model_en = 1'b0;

  task automatic model_reset();
    mpc = '0; mac = '0; me = 1'b0; mhalted = 1'b1;
  endtask

  // Executes one whole instruction and reports how many cycles it must take.
  task automatic model_step(output int len);
    logic [15:0] ins, v;
    logic [11:0] ea, code;
    logic [16:0] sum;
    logic [2:0]  opc;
    logic        ib, old_e;
    ins  = mm[mpc[5:0]];
    mpc  = mpc + 12'd1;
    ib   = ins[15];
    opc  = ins[14:12];
    code = ins[11:0];
    if (opc == 3'd7) begin
      len = 4;
      if (!ib && $countones(code) == 1) begin
        old_e = me;
        if (code == 12'h800) mac = 16'h0000;
        if (code == 12'h400) me = 1'b0;
        if (code == 12'h200) mac = ~mac;
        if (code == 12'h100) me = ~me;
        if (code == 12'h080) begin me = mac[0];  mac = (mac >> 1) | (16'(old_e) << 15); end
        if (code == 12'h040) begin me = mac[15]; mac = (mac << 1) | 16'(old_e); end
        if (code == 12'h020) mac = mac + 16'd1;
        if (code == 12'h010 && mac < 16'h8000)  mpc = mpc + 12'd1;
        if (code == 12'h008 && mac >= 16'h8000) mpc = mpc + 12'd1;
        if (code == 12'h004 && mac == 16'h0000) mpc = mpc + 12'd1;
        if (code == 12'h002 && me == 1'b0)      mpc = mpc + 12'd1;
        if (code == 12'h001) mhalted = 1'b1;
      end
    end else begin
      ea = ib ? mm[code[5:0]][11:0] : code;
      case (opc)
        3'd0: begin mac = mac & mm[ea[5:0]]; len = 6; end
        3'd1: begin sum = 17'(mac) + 17'(mm[ea[5:0]]); mac = sum[15:0]; me = sum[16]; len = 6; end
        3'd2: begin mac = mm[ea[5:0]]; len = 6; end
        3'd3: begin mm[ea[5:0]] = mac; len = 5; end
        3'd4: begin mpc = ea; len = 5; end
        3'd5: begin mm[ea[5:0]] = 16'(mpc); mpc = ea + 12'd1; len = 6; end
        default: begin
          v = mm[ea[5:0]] + 16'd1;
          mm[ea[5:0]] = v;
          if (v == 16'h0000) mpc = mpc + 12'd1;
          len = 7;
        end
      endcase
    end
  endtask

  // Compare process: T-state and instr_done each running cycle, then the
  // architectural state right after every instruction completes.
  int  cyc = 0;
  int  m_len = 0;
  bit  post_pending = 1'b0;

  always @(negedge clk) begin
    if (!model_en) begin
      cyc = 0;
      post_pending = 1'b0;
    end else begin
      if (post_pending) begin
        check("model_pc", 32'(pc_o), 32'(mpc));
        check("model_ac", 32'(ac_o), 32'(mac));
        check("model_e", 32'(e_o), 32'(me));
        check("model_halted", 32'(halted), 32'(mhalted));
        post_pending = 1'b0;
      end
      if (!halted) begin
        if (cyc == 0) begin
          mhalted = 1'b0;
          model_step(m_len);
        end
        check("model_sc", 32'(sc_o), 32'(cyc));
        check("model_instr_done", 32'(instr_done), 32'(cyc == m_len - 1));
        if (cyc == m_len - 1) begin
          cyc = 0;
          post_pending = 1'b1;
        end else begin
          cyc++;
        end
      end
    end
  end

  // All driving tasks are entered just after a falling edge.
  task automatic load(input int a, input logic [15:0] d);
    prog_we = 1'b1; prog_addr = 6'(a); prog_data = d;
    @(negedge clk);
    prog_we = 1'b0;
    mm[a] = d;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic start_cpu();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_halt(output int cycles, output int dones);
    cycles = 0; dones = 0;
    while (!halted && cycles < 2000) begin
      cycles++;
      if (instr_done) dones++;
      @(negedge clk);
    end
    check("halt_within_budget", 32'(halted), 32'd1);
  endtask

  int cycles, dones, k;

  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;

    check("reset_halted", 32'(halted), 32'd1);
    check("reset_pc", 32'(pc_o), 32'h000);
    check("reset_ac", 32'(ac_o), 32'h0000);
    check("reset_e", 32'(e_o), 32'd0);
    check("reset_sc", 32'(sc_o), 32'd0);
    check("reset_instr_done", 32'(instr_done), 32'd0);

    for (int a = 0; a < 64; a++) load(a, 16'h0000);
    model_en = 1'b1;

    // CLA; INC; HLT
    load(0, 16'h7800); load(1, 16'h7020); load(2, 16'h7001);
    start_cpu();
    wait_halt(cycles, dones);
    check("basic_cycles", 32'(cycles), 32'd12);
    check("basic_done_pulses", 32'(dones), 32'd3);
    check("basic_ac", 32'(ac_o), 32'h0001);
    check("basic_pc", 32'(pc_o), 32'h003);

    // LDA 10; ADD 11 -> carry out
    do_reset();
    load(0, 16'h200A); load(1, 16'h100B); load(2, 16'h7001);
    load(10, 16'hFFFF); load(11, 16'h0002);
    start_cpu();
    wait_halt(cycles, dones);
    check("add_ac", 32'(ac_o), 32'h0001);
    check("add_e", 32'(e_o), 32'd1);
    check("add_pc", 32'(pc_o), 32'h003);

    // Indirect LDA: 6 cycles + HLT 4 cycles
    do_reset();
    load(0, 16'hA00A); load(1, 16'h7001);
    load(10, 16'h000C); load(12, 16'h1234);
    start_cpu();
    wait_halt(cycles, dones);
    check("lda_ind_ac", 32'(ac_o), 32'h1234);
    check("lda_ind_cycles", 32'(cycles), 32'd10);

    // ISZ wraps FFFF -> 0 and skips; second run reads the word back
    do_reset();
    load(0, 16'h600A); load(1, 16'h7001); load(2, 16'h7001);
    load(3, 16'h7200); load(4, 16'h200A); load(5, 16'h7001);
    load(10, 16'hFFFF);
    start_cpu();
    wait_halt(cycles, dones);
    check("isz_pc", 32'(pc_o), 32'h003);
    check("isz_cycles", 32'(cycles), 32'd11);
    start_cpu();
    wait_halt(cycles, dones);
    check("isz_word_zero", 32'(ac_o), 32'h0000);
    check("isz_resume_pc", 32'(pc_o), 32'h006);

    // BSA 16: return address stored, jump to 17; then LDA 16 to read it
    do_reset();
    load(0, 16'h5010); load(17, 16'h7001);
    load(18, 16'h2010); load(19, 16'h7001);
    start_cpu();
    wait_halt(cycles, dones);
    check("bsa_pc", 32'(pc_o), 32'h012);
    start_cpu();
    wait_halt(cycles, dones);
    check("bsa_saved_ret", 32'(ac_o), 32'h0001);
    check("bsa_resume_pc", 32'(pc_o), 32'h014);

    // AND, ADD without carry, BUN
    do_reset();
    load(0, 16'h7200); load(1, 16'h000A); load(2, 16'h100B);
    load(3, 16'h4005); load(4, 16'h7001); load(5, 16'h7001);
    load(10, 16'h0F0F); load(11, 16'h00F1);
    start_cpu();
    wait_halt(cycles, dones);
    check("and_add_ac", 32'(ac_o), 32'h1000);
    check("and_add_e", 32'(e_o), 32'd0);
    check("bun_pc", 32'(pc_o), 32'h006);

    // Register-reference mix with skips, a non-one-hot NOP and an I/O NOP
    do_reset();
    load(0, 16'h7800);  load(1, 16'h7200);  load(2, 16'h7080);  load(3, 16'h7040);
    load(4, 16'h7100);  load(5, 16'h7002);  load(6, 16'h7400);  load(7, 16'h7002);
    load(8, 16'h7001);  load(9, 16'h7008);  load(10, 16'h7001); load(11, 16'h7003);
    load(12, 16'hF001); load(13, 16'h7020); load(14, 16'h7004); load(15, 16'h7001);
    load(16, 16'h7010); load(17, 16'h7001); load(18, 16'h7020); load(19, 16'h7001);
    start_cpu();
    wait_halt(cycles, dones);
    check("regref_ac", 32'(ac_o), 32'h0001);
    check("regref_e", 32'(e_o), 32'd0);
    check("regref_pc", 32'(pc_o), 32'h014);
    check("regref_instrs", 32'(dones), 32'd16);

    // prog_we while running must be ignored
    do_reset();
    load(0, 16'h7020); load(1, 16'h7020); load(2, 16'h200A); load(3, 16'h7001);
    load(10, 16'h5555);
    start_cpu();
    @(negedge clk);
    prog_we = 1'b1; prog_addr = 6'd10; prog_data = 16'hAAAA;
    @(negedge clk);
    prog_we = 1'b0;
    wait_halt(cycles, dones);
    check("prog_we_running_ignored", 32'(ac_o), 32'h5555);

    // rst during T4 of STA aborts it and suppresses the store
    do_reset();
    load(0, 16'h7200); load(1, 16'h300A); load(2, 16'h7001);
    load(10, 16'h1234);
    model_en = 1'b0;
    start_cpu();
    k = 0;
    while (sc_o != 3'd4 && k < 50) begin
      @(negedge clk);
      k++;
    end
    check("sta_reached_t4", 32'(sc_o), 32'd4);
    do_reset();
    check("abort_halted", 32'(halted), 32'd1);
    check("abort_pc", 32'(pc_o), 32'h000);
    check("abort_ac", 32'(ac_o), 32'h0000);
    model_en = 1'b1;
    load(0, 16'h200A); load(1, 16'h7001);
    start_cpu();
    wait_halt(cycles, dones);
    check("abort_store_suppressed", 32'(ac_o), 32'h1234);

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mano_cpu.md
MANO_CPU -- requirements
Module: mano_cpu

Interface
REQ-001 Parameter DW, default 16: data and instruction width; SHALL be ≥ 16.
REQ-002 Parameter MEM_AW, default 6: memory index bits (depth 2^MEM_AW); SHALL be ≤ 12.
REQ-003 clk  in  1  clock; all state changes on rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 start  in  1  begins execution at current PC when halted.
REQ-006 prog_we  in  1  program-load write strobe.
REQ-007 prog_addr  in  MEM_AW  program-load address.
REQ-008 prog_data  in  DW  program-load data.
REQ-009 halted  out  1  core stopped.
REQ-010 instr_done  out  1  one-cycle pulse on the final cycle of each instruction.
REQ-011 pc_o  out  12  program counter.
REQ-012 ac_o  out  DW  accumulator.
REQ-013 e_o  out  1  carry/extend flag.
REQ-014 sc_o  out  3  sequence counter (T-state).

Function
REQ-015 Instruction fields SHALL be: I = IR[15], opcode = IR[14:12], address = IR[11:0]; IR[DW-1:16] is ignored.
REQ-016 Memory SHALL be 2^MEM_AW x DW, written synchronously, read combinationally, indexed by AR[MEM_AW-1:0] (upper AR bits alias).
REQ-017 Fetch: T0 AR<-PC; T1 IR<-M[AR], PC<-PC+1; T2 AR<-IR[11:0], I latched.
REQ-018 T3 for a memory-reference instruction (opcode ≠ 7) SHALL load AR<-M[AR] if I=1 and do nothing otherwise.
REQ-019 Memory-reference execution: AND/ADD/LDA: T4 DR<-M[AR], T5 AC<-AC&DR / {E,AC}<-AC+DR (DW+1-bit sum) / AC<-DR. STA: T4 M[AR]<-AC. BUN: T4 PC<-AR. BSA: T4 M[AR]<-PC (zero-extended), AR<-AR+1; T5 PC<-AR. ISZ: T4 DR<-M; T5 DR<-DR+1; T6 M[AR]<-DR, PC<-PC+1 if DR==0.
REQ-020 Opcode 7, I=0: register-reference instruction executed in T3 on IR[11:0] one-hot codes.
REQ-020a Codes: CLA 800, CLE 400, CMA 200, CME 100, CIR 080 ({AC,E} rotate right), CIL 040 ({AC,E} rotate left), INC 020, SPA 010 (skip if AC[DW-1]=0), SNA 008 (skip if AC[DW-1]=1), SZA 004 (skip if AC=0), SZE 002 (skip if E=0), HLT 001.
REQ-021 A non-one-hot register code, or opcode 7 with I=1 (I/O), SHALL execute as a NOP completing in T3.
REQ-022 SC SHALL clear to 0 and instr_done SHALL pulse on the last T-state of every instruction.
REQ-022a Instruction lengths: register/NOP 4 cycles, STA/BUN 5, AND/ADD/LDA/BSA 6, ISZ 7.
REQ-023 HLT SHALL set halted in T3; no further fetch until start.
REQ-024 While halted, start=1 SHALL begin T0 on the next cycle with PC unchanged. start while running SHALL be ignored.
REQ-025 prog_we SHALL write M[prog_addr]<-prog_data only while halted; it is ignored while running. prog_we and start in the same cycle SHALL both take effect.
REQ-026 PC and AR arithmetic SHALL wrap modulo 2^12; AC increment wraps modulo 2^DW without touching E.

Reset
REQ-027 rst SHALL set PC=0, AC=0, E=0, AR=0, DR=0, IR=0, SC=0, halted=1, instr_done=0.
REQ-028 rst mid-instruction SHALL abort the instruction; any memory write in that cycle SHALL be suppressed; memory contents are otherwise preserved.

Structure
REQ-029 Package mano_pkg SHALL hold opcode constants, register-reference code constants and T-state constants.
REQ-030 Combinational AC/E operations (AND, ADD, complement, rotates, increment) SHALL be a sub-module mano_alu.

Verification
REQ-031 Load M0=7800, M1=7020, M2=7001; start -> halted after 12 cycles, AC=0001, PC=003, three instr_done pulses.
REQ-032 M0=200A, M1=100B, M2=7001, M10=FFFF, M11=0002 -> AC=0001, E=1, PC=003.
REQ-033 M0=A00A, M1=7001, M10=000C, M12=1234 -> AC=1234; the LDA takes 6 cycles.
REQ-034 M0=600A, M1=7001, M2=7001, M10=FFFF -> M10=0000, skip taken, PC=003 when halted.
REQ-035 M0=5010, M17=7001 -> M16=0001, halted with PC=012 (hex).
REQ-036 prog_we while running -> memory unchanged; rst at T4 of an STA -> target word unchanged, halted=1, PC=0.
